// File: rtl/alu_exec_pkg.sv
// Shared types and the single-cycle ALU function for the 8-bit CPU execute stage.
package alu_exec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Result of a single-cycle op; operands are zero-extended to 32 bits so the
  // function serves any data path width up to 32.
  typedef struct packed {
    logic [31:0] res;
    logic        cry;
  } sc_res_t;

  function automatic logic is_single(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  // ADD/SUB/AND/OR/XOR of w-bit operands: result masked to w bits, carry is
  // the ADD carry out, the SUB borrow, or 0 for the logic ops.
  function automatic sc_res_t alu_single(input op_t op, input logic [31:0] a,
                                         input logic [31:0] b, input int unsigned w);
    logic [32:0] full;
    logic [31:0] mask;
    sc_res_t     r;
    full = '0;
    r    = '0;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    case (op)
      OP_ADD: begin
        full  = {1'b0, a} + {1'b0, b};
        // Operands are below 2^w, so the sum shifted by w is exactly the carry.
        r.cry = |(full >> w);
      end
      OP_SUB: begin
        full  = {1'b0, a - b};
        r.cry = (a < b);
      end
      OP_AND:  full = {1'b0, a & b};
      OP_OR:   full = {1'b0, a | b};
      OP_XOR:  full = {1'b0, a ^ b};
      default: full = {1'b0, a};
    endcase
    r.res = full[31:0] & mask;
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_iter.sv
// Iterative datapath for SHL/SHR/MUL: one shift bit or one shift-add step per
// RUN cycle. Exposes the post-step value so the FSM can capture it on entry to WB.
module mul_shift_iter import alu_exec_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         step_i,
  input  op_t          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         last_o,
  output logic [W-1:0] res_o,
  output logic         cry_o
);
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W + 1);

  op_t            op_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplr_q;

  // One iteration step; shifts keep their operand in the low half of acc.
  always_comb begin
    acc_d = acc_q;
    cry_o = 1'b0;
    case (op_q)
      OP_MUL: begin
        acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
        cry_o = |acc_d[2*W-1:W];
      end
      OP_SHL: begin
        acc_d = {{W{1'b0}}, acc_q[W-2:0], 1'b0};
        cry_o = acc_q[W-1];
      end
      OP_SHR: begin
        acc_d = {{W{1'b0}}, 1'b0, acc_q[W-1:1]};
        cry_o = acc_q[0];
      end
      default: ;
    endcase
    res_o  = acc_d[W-1:0];
    last_o = (cnt_q == CW'(1));
  end

  // Load operands on accept, then advance once per RUN cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= OP_ADD;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else if (load_i) begin
      op_q    <= op_i;
      cnt_q   <= (op_i == OP_MUL) ? CW'(W) : CW'(b_i[SW-1:0]);
      acc_q   <= (op_i == OP_MUL) ? '0 : {{W{1'b0}}, a_i};
      mcand_q <= {{W{1'b0}}, a_i};
      mplr_q  <= b_i;
    end else if (step_i) begin
      cnt_q   <= cnt_q - CW'(1);
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: start/busy handshake, IDLE/RUN/WB FSM and the registered
// write-port outputs and branch flags.
module alu_exec import alu_exec_pkg::*; #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  op_t          Op,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  input  logic [D-1:0] Dest,
  output logic         Busy,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataOut,
  output logic         Zero,
  output logic         Carry
);
  localparam int SW = $clog2(W);

  state_t       state_q, state_d;
  logic [D-1:0] dest_q, dest_d;
  logic [D-1:0] waddr_q, waddr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         zero_q, zero_d;
  logic         carry_q, carry_d;
  logic         we_q;
  logic         upd;

  logic         it_load, it_step, it_last, it_cry;
  logic [W-1:0] it_res;
  sc_res_t      sc;
  logic         unused_sc;

  assign sc        = alu_single(Op, 32'(InA), 32'(InB), W);
  assign unused_sc = ^sc.res;

  mul_shift_iter #(.W(W)) u_iter (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .load_i (it_load),
    .step_i (it_step),
    .op_i   (Op),
    .a_i    (InA),
    .b_i    (InB),
    .last_o (it_last),
    .res_o  (it_res),
    .cry_o  (it_cry)
  );

  // Next state; result, address and flags are only reloaded on entry to WB.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    waddr_d = waddr_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    upd     = 1'b0;
    it_load = 1'b0;
    it_step = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin
        dest_d = Dest;
        if (is_single(Op)) begin
          state_d = S_WB;
          upd     = 1'b1;
          waddr_d = Dest;
          dout_d  = sc.res[W-1:0];
          carry_d = sc.cry;
        end else if (Op != OP_MUL && InB[SW-1:0] == '0) begin
          // Zero-length shift: pass A through with no bit shifted out.
          state_d = S_WB;
          upd     = 1'b1;
          waddr_d = Dest;
          dout_d  = InA;
          carry_d = 1'b0;
        end else begin
          state_d = S_RUN;
          it_load = 1'b1;
        end
      end
      S_RUN: begin
        it_step = 1'b1;
        if (it_last) begin
          state_d = S_WB;
          upd     = 1'b1;
          waddr_d = dest_q;
          dout_d  = it_res;
          carry_d = it_cry;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    zero_d = upd ? (dout_d == '0) : zero_q;
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      dest_q  <= '0;
      waddr_q <= '0;
      dout_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      waddr_q <= waddr_d;
      dout_q  <= dout_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      we_q    <= (state_d == S_WB);
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign WriteEn = we_q;
  assign Waddr   = waddr_q;
  assign DataOut = dout_q;
  assign Zero    = zero_q;
  assign Carry   = carry_q;

endmodule
